// File: rtl/spi_pkg.sv
// ============================================================================
// Module   : spi_pkg
// Brief    : Shared command encodings, frame widths and FSM states for the SPI master.
// Revision : 1.0
// ============================================================================
`default_nettype none

package spi_pkg;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

   localparam int FRAME_W = 10;
   localparam int DATA_W  = 8;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SHIFT = 3'd1,
      S_TURN  = 3'd2,
      S_READ  = 3'd3,
      S_GAP   = 3'd4
   } state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

`default_nettype wire

// File: rtl/spi_shift_reg.sv
// ============================================================================
// Module   : spi_shift_reg
// Brief    : Parallel-load, MSB-first shift register; load has priority over shift.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spi_shift_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_data,
   input  logic         i_shift,
   input  logic         i_sin,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q <= '0;
      end else if (i_load) begin
         r_q <= i_load_data;
      end else if (i_shift) begin
         r_q <= {r_q[W-2:0], i_sin};
      end
   end

   assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/spi_master_ctrl.sv
// ============================================================================
// Module   : spi_master_ctrl
// Brief    : SPI master issuing 10-bit command frames, with an 8-bit read-back for read-data.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spi_master_ctrl
   import spi_pkg::*;
#(
   parameter int RD_TURN = 3,
   parameter int GAP     = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_cmd,
   input  logic [7:0]        req_payload,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              SS_n,
   output logic              MOSI,
   input  logic              MISO
);

   localparam int GAP_LEN = (GAP < 1) ? 1 : GAP;
   localparam int CNT_MAX = max3(FRAME_W - 1, RD_TURN, GAP_LEN);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] c_FRAME_LD = CNT_W'(FRAME_W - 1);
   localparam logic [CNT_W-1:0] c_READ_LD  = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] c_TURN_LD  = CNT_W'((RD_TURN > 0) ? RD_TURN - 1 : 0);
   localparam logic [CNT_W-1:0] c_GAP_LD   = CNT_W'(GAP_LEN - 1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [CNT_W-1:0]    r_cnt;
   logic [CNT_W-1:0]    w_cnt_nxt;
   logic                r_is_rd;
   logic [DATA_W-1:0]   r_rd_data;
   logic                r_rd_valid;
   logic                w_accept;
   logic [FRAME_W-1:0]  w_tx_q;
   logic [DATA_W-1:0]   w_rx_q;
   logic                w_unused;

   assign w_accept = req_valid && (r_state == S_IDLE);

   spi_shift_reg #(.W(FRAME_W)) u_tx (
      .clk         (clk),
      .rst         (rst),
      .i_load      (w_accept),
      .i_load_data ({req_cmd, req_payload}),
      .i_shift     (r_state == S_SHIFT),
      .i_sin       (1'b0),
      .o_q         (w_tx_q)
   );

   spi_shift_reg #(.W(DATA_W)) u_rx (
      .clk         (clk),
      .rst         (rst),
      .i_load      (w_accept),
      .i_load_data ('0),
      .i_shift     (r_state == S_READ),
      .i_sin       (MISO),
      .o_q         (w_rx_q)
   );

   // Only the MSB of tx and the low bits of rx feed the outputs.
   assign w_unused = ^{w_tx_q[FRAME_W-2:0], w_rx_q[DATA_W-1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      SS_n        = 1'b0;
      MOSI        = 1'b0;
      busy        = 1'b1;
      req_ready   = 1'b0;
      case (r_state)
         S_IDLE: begin
            SS_n      = 1'b1;
            busy      = 1'b0;
            req_ready = 1'b1;
            if (req_valid) begin
               w_state_nxt = S_SHIFT;
               w_cnt_nxt   = c_FRAME_LD;
            end
         end
         S_SHIFT: begin
            MOSI = w_tx_q[FRAME_W-1];
            if (r_cnt == '0) begin
               if (!r_is_rd) begin
                  w_state_nxt = S_GAP;
                  w_cnt_nxt   = c_GAP_LD;
               end else if (RD_TURN == 0) begin
                  w_state_nxt = S_READ;
                  w_cnt_nxt   = c_READ_LD;
               end else begin
                  w_state_nxt = S_TURN;
                  w_cnt_nxt   = c_TURN_LD;
               end
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         S_TURN: begin
            if (r_cnt == '0) begin
               w_state_nxt = S_READ;
               w_cnt_nxt   = c_READ_LD;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         S_READ: begin
            if (r_cnt == '0) begin
               w_state_nxt = S_GAP;
               w_cnt_nxt   = c_GAP_LD;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         S_GAP: begin
            SS_n = 1'b1;
            if (r_cnt == '0) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // The last MISO bit is merged directly so rd_data is ready in the first GAP cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_is_rd    <= 1'b0;
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= 1'b0;
         if (w_accept) begin
            r_is_rd <= (req_cmd == CMD_RD_DATA);
         end
         if ((r_state == S_READ) && (r_cnt == '0)) begin
            r_rd_data  <= {w_rx_q[DATA_W-2:0], MISO};
            r_rd_valid <= 1'b1;
         end
      end
   end

   assign rd_data  = r_rd_data;
   assign rd_valid = r_rd_valid;

endmodule

`default_nettype wire

// File: tb/tb_spi_master_ctrl.sv
// ============================================================================
// Module   : tb_spi_master_ctrl
// Brief    : Directed bench for spi_master_ctrl with an SPI slave/RAM model and read scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_spi_master_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic [1:0] req_cmd = 2'b00;
   logic [7:0] req_payload = 8'h00;
   logic       MISO;
   logic       req_ready, rd_valid, busy, SS_n, MOSI;
   logic [7:0] rd_data;

   int checks = 0;
   int errors = 0;
   int rv_cnt = 0;

   logic [7:0] exp_q[$];
   logic [9:0] words[$];
   int         lens[$];
   int         gaps[$];

   spi_master_ctrl #(.RD_TURN(3), .GAP(1)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_cmd     (req_cmd),
      .req_payload (req_payload),
      .rd_valid    (rd_valid),
      .rd_data     (rd_data),
      .busy        (busy),
      .SS_n        (SS_n),
      .MOSI        (MOSI),
      .MISO        (MISO)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Slave/RAM model: decodes each frame from MOSI and answers read-data on MISO.
   logic [7:0] ram [256];
   logic [7:0] maddr;
   logic [7:0] rbyte;
   logic [9:0] word;
   int         k;
   int         hi;

   always @(negedge clk) begin
      if (rst) begin
         k = 0;
         hi = 0;
         MISO = 1'b0;
         maddr = 8'h00;
         rbyte = 8'h00;
         word = 10'h000;
         ram[8'hA5] = 8'h3C;
      end else if (SS_n) begin
         if (k != 0) begin
            lens.push_back(k);
            words.push_back(word);
         end
         k = 0;
         hi++;
         MISO = 1'b0;
      end else begin
         if (k == 0) begin
            gaps.push_back(hi);
            hi = 0;
         end
         if (k < 10) word = {word[8:0], MOSI};
         if (k == 9) begin
            case (word[9:8])
               2'b00: maddr = word[7:0];
               2'b01: ram[maddr] = word[7:0];
               2'b10: maddr = word[7:0];
               default: rbyte = ram[maddr];
            endcase
         end
         if (k >= 13 && k <= 20) MISO = rbyte[20 - k];
         else                    MISO = (k >= 10);
         k++;
      end
   end

   // Read scoreboard: every rd_valid pulse must match the oldest expected byte.
   always @(negedge clk) begin
      if (!rst && rd_valid) begin
         rv_cnt++;
         if (exp_q.size() == 0) chk("rd_unexpected", {31'b0, rd_valid}, 32'd0);
         else                   chk("rd_data", {24'b0, rd_data}, {24'b0, exp_q.pop_front()});
         chk("rd_valid_in_gap", {31'b0, SS_n}, 32'd1);
      end
   end

   task automatic send(input logic [1:0] c, input logic [7:0] p);
      int n = 0;
      while (!req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) chk("send_timeout", {31'b0, req_ready}, 32'd1);
      req_cmd = c;
      req_payload = p;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      @(negedge clk);
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (busy) chk({tag, "_idle_timeout"}, {31'b0, busy}, 32'd0);
      @(negedge clk);
   endtask

   task automatic pop_frame(input string tag, input logic [9:0] ew, input int el, output int g);
      g = -1;
      if (words.size() == 0 || gaps.size() == 0) begin
         chk({tag, "_frame_missing"}, words.size(), 32'd1);
      end else begin
         chk({tag, "_mosi_word"}, {22'b0, words.pop_front()}, {22'b0, ew});
         chk({tag, "_ss_low_len"}, lens.pop_front(), el);
         g = gaps.pop_front();
      end
   endtask

   initial begin
      int n;
      int g;
      int rv0;

      // Reset values while rst is held
      repeat (2) @(negedge clk);
      chk("rst_ss_n", {31'b0, SS_n}, 32'd1);
      chk("rst_mosi", {31'b0, MOSI}, 32'd0);
      chk("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
      chk("rst_rd_data", {24'b0, rd_data}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
      #2 rst = 1'b0;
      @(negedge clk);

      // Write address A5
      send(2'b00, 8'hA5);
      chk("t1_busy", {31'b0, busy}, 32'd1);
      n = 0;
      while (!SS_n && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("t1_gap_ss_n", {31'b0, SS_n}, 32'd1);
      chk("t1_gap_not_ready", {31'b0, req_ready}, 32'd0);
      @(negedge clk);
      chk("t1_ready_back", {31'b0, req_ready}, 32'd1);
      pop_frame("t1", 10'h0A5, 10, g);
      chk("t1_no_rd_valid", rv_cnt, 32'd0);

      // Read data from the address just written (model preloads 3C there)
      exp_q.push_back(8'h3C);
      send(2'b11, 8'h00);
      wait_idle("t2");
      pop_frame("t2", 10'h300, 21, g);
      chk("t2_rd_pulses", rv_cnt, 32'd1);
      chk("t2_rd_data_hold", {24'b0, rd_data}, 32'h3C);

      // Back-to-back with req_valid held high
      req_cmd = 2'b01;
      req_payload = 8'hFF;
      req_valid = 1'b1;
      @(negedge clk);
      req_cmd = 2'b10;
      req_payload = 8'h00;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      req_valid = 1'b0;
      chk("t3_second_busy", {31'b0, busy}, 32'd1);
      wait_idle("t3");
      pop_frame("t3a", 10'h1FF, 10, g);
      pop_frame("t3b", 10'h200, 10, g);
      chk("t3_gap_high_cycles", g, 32'd2);

      // Request pulse mid-frame is ignored
      send(2'b00, 8'h33);
      repeat (3) @(negedge clk);
      chk("t4_ready_low", {31'b0, req_ready}, 32'd0);
      req_cmd = 2'b11;
      req_payload = 8'hCC;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      wait_idle("t4");
      pop_frame("t4", 10'h033, 10, g);
      repeat (4) @(negedge clk);
      chk("t4_no_extra_frame", gaps.size(), 32'd0);
      chk("t4_idle", {31'b0, busy}, 32'd0);

      // Reset during READ bit 4
      rv0 = rv_cnt;
      send(2'b11, 8'h00);
      repeat (16) @(negedge clk);
      chk("t5_in_frame", {31'b0, SS_n}, 32'd0);
      #2 rst = 1'b1;
      #1;
      chk("t5_ss_n_async", {31'b0, SS_n}, 32'd1);
      chk("t5_mosi_async", {31'b0, MOSI}, 32'd0);
      chk("t5_busy_async", {31'b0, busy}, 32'd0);
      chk("t5_rd_data_clr", {24'b0, rd_data}, 32'd0);
      @(negedge clk);
      #2 rst = 1'b0;
      words.delete();
      lens.delete();
      gaps.delete();
      repeat (25) @(negedge clk);
      chk("t5_no_rd_valid", rv_cnt, rv0);

      // End-to-end through the RAM model
      send(2'b00, 8'h10);
      wait_idle("t6a");
      send(2'b01, 8'h5A);
      wait_idle("t6b");
      send(2'b10, 8'h10);
      wait_idle("t6c");
      exp_q.push_back(8'h5A);
      send(2'b11, 8'h00);
      wait_idle("t6d");
      pop_frame("t6a", 10'h010, 10, g);
      pop_frame("t6b", 10'h15A, 10, g);
      pop_frame("t6c", 10'h210, 10, g);
      pop_frame("t6d", 10'h300, 21, g);
      chk("t6_rd_data", {24'b0, rd_data}, 32'h5A);
      chk("t6_rd_pulses", rv_cnt, rv0 + 1);
      chk("t6_scoreboard_empty", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
